// File: rtl/packet_length_checker.sv
// packet_length_checker: inline AXI-Stream length/TKEEP checker. Marks malformed
// packets with TUSER=1 on their TLAST beat, truncates oversize packets at
// MAX_BEATS and drops their tail, and keeps saturating packet statistics.
module packet_length_checker #(
    parameter int DW        = 512,
    parameter int MIN_BEATS = 1,
    parameter int MAX_BEATS = 64,
    parameter int CW        = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DW-1:0]     AXIS_IN_TDATA,
    input  logic [DW/8-1:0]   AXIS_IN_TKEEP,
    input  logic              AXIS_IN_TUSER,
    input  logic              AXIS_IN_TLAST,
    input  logic              AXIS_IN_TVALID,
    output logic              AXIS_IN_TREADY,
    output logic [DW-1:0]     AXIS_OUT_TDATA,
    output logic [DW/8-1:0]   AXIS_OUT_TKEEP,
    output logic              AXIS_OUT_TUSER,
    output logic              AXIS_OUT_TLAST,
    output logic              AXIS_OUT_TVALID,
    input  logic              AXIS_OUT_TREADY,
    output logic              bad_packet_strb,
    output logic [CW-1:0]     packet_count,
    output logic [CW-1:0]     bad_packet_count
);

    localparam int KW  = DW / 8;
    localparam int BCW = $clog2(MAX_BEATS + 1);
    localparam logic [BCW-1:0] MIN_B = BCW'(MIN_BEATS);
    localparam logic [BCW-1:0] MAX_B = BCW'(MAX_BEATS);

    typedef enum logic {
        ST_PASS    = 1'b0,
        ST_DISCARD = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
    logic           err_sticky_q, err_sticky_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic           out_user_q, out_user_d;
    logic           strb_q, strb_d;
    logic [CW-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CW-1:0]  bad_cnt_q, bad_cnt_d;
    logic [DW-1:0]  out_data_q;
    logic [KW-1:0]  out_keep_q;

    logic           in_ready;
    logic           in_acc;
    logic           load;
    logic [BCW-1:0] beats_seen;
    logic [KW-1:0]  keep_plus1;
    logic           keep_full;
    logic           keep_last_ok;
    logic           runt;
    logic           truncate;
    logic           last_out;
    logic           last_err;
    logic           mark;

    // In DISCARD the tail is swallowed regardless of the output; in PASS the
    // single register slice accepts when empty or draining this cycle.
    assign in_ready = (state_q == ST_DISCARD) | ~out_valid_q | AXIS_OUT_TREADY;
    assign in_acc   = AXIS_IN_TVALID & in_ready;
    assign load     = in_acc & (state_q == ST_PASS);

    // Beat number (1-based) of the beat currently on the input.
    assign beats_seen = beat_cnt_q + BCW'(1);

    // A last-beat TKEEP is legal when it is a non-empty run of ones from the LSB.
    assign keep_full    = &AXIS_IN_TKEEP;
    assign keep_plus1   = AXIS_IN_TKEEP + KW'(1);
    assign keep_last_ok = (AXIS_IN_TKEEP != '0) && ((AXIS_IN_TKEEP & keep_plus1) == '0);

    assign runt     = beats_seen < MIN_B;
    assign truncate = ~AXIS_IN_TLAST & (beats_seen == MAX_B);
    assign last_out = AXIS_IN_TLAST | truncate;
    assign last_err = AXIS_IN_TUSER | ~keep_last_ok | runt;
    assign mark     = truncate | (AXIS_IN_TLAST & (err_sticky_q | last_err));

    // Next-state logic for the FSM, packet tracking, output slice and statistics.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        err_sticky_d = err_sticky_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_user_d   = out_user_q;
        strb_d       = 1'b0;
        pkt_cnt_d    = pkt_cnt_q;
        bad_cnt_d    = bad_cnt_q;

        case (state_q)
            ST_PASS: begin
                if (in_acc) begin
                    if (last_out) begin
                        beat_cnt_d   = '0;
                        err_sticky_d = 1'b0;
                        if (truncate) begin
                            state_d = ST_DISCARD;
                        end
                    end else begin
                        beat_cnt_d   = beats_seen;
                        err_sticky_d = err_sticky_q | AXIS_IN_TUSER | ~keep_full;
                    end
                end
            end
            ST_DISCARD: begin
                // The truncated beat already counted the packet; only watch for its end.
                if (in_acc && AXIS_IN_TLAST) begin
                    state_d = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_last_d  = last_out;
            out_user_d  = mark;
            strb_d      = mark;
            if (last_out) begin
                if (pkt_cnt_q != '1) begin
                    pkt_cnt_d = pkt_cnt_q + CW'(1);
                end
                if (mark && (bad_cnt_q != '1)) begin
                    bad_cnt_d = bad_cnt_q + CW'(1);
                end
            end
        end else if (AXIS_OUT_TREADY) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and statistics registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_PASS;
            beat_cnt_q   <= '0;
            err_sticky_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_user_q   <= 1'b0;
            strb_q       <= 1'b0;
            pkt_cnt_q    <= '0;
            bad_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            err_sticky_q <= err_sticky_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_user_q   <= out_user_d;
            strb_q       <= strb_d;
            pkt_cnt_q    <= pkt_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

    // Wide payload register, loaded on every forwarded beat.
    always_ff @(posedge clk) begin
        // NOTE: payload is left out of reset; it is only observed while TVALID=1.
        if (load) begin
            out_data_q <= AXIS_IN_TDATA;
            out_keep_q <= AXIS_IN_TKEEP;
        end
    end

    assign AXIS_IN_TREADY   = in_ready;
    assign AXIS_OUT_TDATA   = out_data_q;
    assign AXIS_OUT_TKEEP   = out_keep_q;
    assign AXIS_OUT_TUSER   = out_user_q;
    assign AXIS_OUT_TLAST   = out_last_q;
    assign AXIS_OUT_TVALID  = out_valid_q;
    assign bad_packet_strb  = strb_q;
    assign packet_count     = pkt_cnt_q;
    assign bad_packet_count = bad_cnt_q;

endmodule

// File: tb/tb_packet_length_checker.sv
// tb_packet_length_checker: directed and randomized stimulus against a
// packet-level reference model with an output scoreboard.
module tb_packet_length_checker;

    localparam int DW        = 128;
    localparam int KW        = DW / 8;
    localparam int MIN_BEATS = 2;
    localparam int MAX_BEATS = 8;
    localparam int CW        = 6;
    localparam int CNT_MAX   = (1 << CW) - 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          user;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] in_data;
    logic [KW-1:0] in_keep;
    logic          in_user;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [KW-1:0] out_keep;
    logic          out_user;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          strb;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] bad_cnt;

    packet_length_checker #(
        .DW(DW), .MIN_BEATS(MIN_BEATS), .MAX_BEATS(MAX_BEATS), .CW(CW)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .AXIS_IN_TDATA    (in_data),
        .AXIS_IN_TKEEP    (in_keep),
        .AXIS_IN_TUSER    (in_user),
        .AXIS_IN_TLAST    (in_last),
        .AXIS_IN_TVALID   (in_valid),
        .AXIS_IN_TREADY   (in_ready),
        .AXIS_OUT_TDATA   (out_data),
        .AXIS_OUT_TKEEP   (out_keep),
        .AXIS_OUT_TUSER   (out_user),
        .AXIS_OUT_TLAST   (out_last),
        .AXIS_OUT_TVALID  (out_valid),
        .AXIS_OUT_TREADY  (out_ready),
        .bad_packet_strb  (strb),
        .packet_count     (pkt_cnt),
        .bad_packet_count (bad_cnt)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t pkt_q[$];
    beat_t exp_q[$];
    int    exp_pkt_cnt    = 0;
    int    exp_bad_cnt    = 0;
    int    exp_strb_total = 0;
    int    strb_seen      = 0;
    bit    bp_random      = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: derive the expected output beats and statistics of
    // the packet in pkt_q directly from the packet-level rules.
    task automatic model_pkt();
        int    n;
        int    n_out;
        int    run;
        bit    bad;
        beat_t b;
        n   = pkt_q.size();
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (pkt_q[i].user) bad = 1'b1;
            if (i < n - 1 && pkt_q[i].keep != {KW{1'b1}}) bad = 1'b1;
        end
        run = 0;
        while (run < KW && pkt_q[n-1].keep[run]) run++;
        if (run == 0 || $countones(pkt_q[n-1].keep) != run) bad = 1'b1;
        if (n < MIN_BEATS) bad = 1'b1;
        n_out = n;
        if (n > MAX_BEATS) begin
            n_out = MAX_BEATS;
            bad   = 1'b1;
        end
        for (int i = 0; i < n_out; i++) begin
            b      = pkt_q[i];
            b.last = (i == n_out - 1);
            b.user = b.last ? bad : 1'b0;
            exp_q.push_back(b);
        end
        if (exp_pkt_cnt < CNT_MAX) exp_pkt_cnt++;
        if (bad) begin
            exp_strb_total++;
            if (exp_bad_cnt < CNT_MAX) exp_bad_cnt++;
        end
    endtask

    task automatic make_pkt(input int len, input logic [KW-1:0] last_keep, input int user_idx);
        beat_t b;
        pkt_q.delete();
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom(), $urandom(), $urandom(), $urandom()};
            b.keep = (i == len - 1) ? last_keep : {KW{1'b1}};
            b.user = (i == user_idx);
            b.last = (i == len - 1);
            pkt_q.push_back(b);
        end
    endtask

    task automatic make_rand_pkt();
        int            len;
        logic [KW-1:0] k;
        len = $urandom_range(1, 11);
        make_pkt(len, {KW{1'b1}}, -1);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 19) == 0) pkt_q[i].user = 1'b1;
            if (i < len - 1) begin
                if ($urandom_range(0, 9) == 0) pkt_q[i].keep = KW'($urandom());
            end else begin
                k = {KW{1'b1}};
                k = k >> $urandom_range(0, KW - 1);
                if ($urandom_range(0, 9) == 0) k = KW'($urandom());
                pkt_q[i].keep = k;
            end
        end
    endtask

    // Present one beat and hold it until accepted; checks the ready rule each cycle.
    task automatic drive_beat(input beat_t b, input bit discard_expected, input int idle);
        int waited;
        bit acc;
        in_valid = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        in_data  = b.data;
        in_keep  = b.keep;
        in_user  = b.user;
        in_last  = b.last;
        in_valid = 1'b1;
        waited   = 0;
        acc      = 1'b0;
        while (!acc && waited < 200) begin
            @(negedge clk);
            if (discard_expected) check("discard_ready", DW'(in_ready), DW'(1));
            else check("bp_ready", DW'(in_ready), DW'(!out_valid || out_ready));
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc && !discard_expected) check("latency", DW'(out_valid), DW'(1));
            waited++;
        end
        if (!acc) check("accept_timeout", DW'(0), DW'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input int idle_max);
        int n;
        n = pkt_q.size();
        model_pkt();
        for (int i = 0; i < n; i++) begin
            drive_beat(pkt_q[i], (n > MAX_BEATS) && (i >= MAX_BEATS), $urandom_range(0, idle_max));
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_timeout", DW'(t < 2000), DW'(1));
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pkt_cnt"}, DW'(pkt_cnt), DW'(exp_pkt_cnt));
        check({tag, "_bad_cnt"}, DW'(bad_cnt), DW'(exp_bad_cnt));
        check({tag, "_strb_cnt"}, DW'(strb_seen), DW'(exp_strb_total));
    endtask

    // Output sink ready: always 1, or 50% random when backpressure is enabled.
    always @(posedge clk) begin
        #1;
        out_ready = bp_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: scoreboard compare, hold-while-stalled and strobe timing.
    beat_t held;
    bit    prev_valid = 1'b0;
    bit    prev_hs    = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        bit    newly;
        if (!resetn) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_valid && !prev_hs) begin
                check("hold_valid", DW'(out_valid), DW'(1));
                check("hold_data", out_data, held.data);
                check("hold_keep", DW'(out_keep), DW'(held.keep));
                check("hold_last", DW'(out_last), DW'(held.last));
                check("hold_user", DW'(out_user), DW'(held.user));
            end
            newly = out_valid && (!prev_valid || prev_hs);
            check("strb", DW'(strb), DW'(newly && out_last && out_user));
            if (strb) strb_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", DW'(1), DW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_keep", DW'(out_keep), DW'(e.keep));
                    check("out_last", DW'(out_last), DW'(e.last));
                    check("out_user", DW'(out_user), DW'(e.user));
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
            held       = '{data: out_data, keep: out_keep, user: out_user, last: out_last};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_keep   = '0;
        in_user   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", DW'(out_valid), DW'(0));
        check("rst_last", DW'(out_last), DW'(0));
        check("rst_user", DW'(out_user), DW'(0));
        check("rst_strb", DW'(strb), DW'(0));
        check("rst_pkt_cnt", DW'(pkt_cnt), DW'(0));
        check("rst_bad_cnt", DW'(bad_cnt), DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(1));
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Good 4-beat packet with a partial last beat.
        make_pkt(4, 16'h00FF, -1);
        send_pkt(0);
        wait_drain();
        check("good_pkt_cnt", DW'(pkt_cnt), DW'(1));
        check("good_bad_cnt", DW'(bad_cnt), DW'(0));
        check("good_strb_cnt", DW'(strb_seen), DW'(0));

        // Runt: single beat below MIN_BEATS.
        make_pkt(1, {KW{1'b1}}, -1);
        send_pkt(0);
        wait_drain();
        check("runt_pkt_cnt", DW'(pkt_cnt), DW'(2));
        check("runt_bad_cnt", DW'(bad_cnt), DW'(1));
        check("runt_strb_cnt", DW'(strb_seen), DW'(1));

        // Giant: 11 beats truncated to 8, then a normal packet.
        make_pkt(11, {KW{1'b1}}, -1);
        send_pkt(0);
        make_pkt(3, {KW{1'b1}}, -1);
        send_pkt(0);
        wait_drain();
        check("giant_pkt_cnt", DW'(pkt_cnt), DW'(4));
        check("giant_bad_cnt", DW'(bad_cnt), DW'(2));

        // Sticky upstream error on beat 2 of 5; illegal last-beat TKEEP.
        make_pkt(5, {KW{1'b1}}, 1);
        send_pkt(0);
        make_pkt(3, 16'h0F0F, -1);
        send_pkt(0);
        // Length boundaries: exactly MAX, exactly MIN, MAX+1, zero last TKEEP.
        make_pkt(MAX_BEATS, {KW{1'b1}}, -1);
        send_pkt(0);
        make_pkt(MIN_BEATS, 16'h0001, -1);
        send_pkt(0);
        make_pkt(MAX_BEATS + 1, {KW{1'b1}}, -1);
        send_pkt(0);
        make_pkt(2, 16'h0000, -1);
        send_pkt(0);
        wait_drain();
        check("directed_pkt_cnt", DW'(pkt_cnt), DW'(10));
        check("directed_bad_cnt", DW'(bad_cnt), DW'(6));
        check_counts("directed");

        // Randomized mixed traffic with 50% output backpressure; the packet
        // counter saturates during this phase.
        bp_random = 1'b1;
        for (int p = 0; p < 100; p++) begin
            make_rand_pkt();
            send_pkt(1);
        end
        wait_drain();
        bp_random = 1'b0;
        @(posedge clk);
        #1;
        check_counts("random");
        check("sat_pkt_cnt", DW'(pkt_cnt), DW'(CNT_MAX));

        // Reset asserted while beat 3 of a 6-beat packet is on the input.
        make_pkt(6, {KW{1'b1}}, -1);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{data: pkt_q[i].data, keep: pkt_q[i].keep, user: 1'b0, last: 1'b0});
            drive_beat(pkt_q[i], 1'b0, 0);
        end
        in_data  = pkt_q[2].data;
        in_keep  = pkt_q[2].keep;
        in_user  = pkt_q[2].user;
        in_last  = pkt_q[2].last;
        in_valid = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_valid", DW'(out_valid), DW'(0));
        check("midrst_last", DW'(out_last), DW'(0));
        check("midrst_user", DW'(out_user), DW'(0));
        check("midrst_strb", DW'(strb), DW'(0));
        check("midrst_pkt_cnt", DW'(pkt_cnt), DW'(0));
        check("midrst_bad_cnt", DW'(bad_cnt), DW'(0));
        in_valid = 1'b0;
        exp_q.delete();
        exp_pkt_cnt    = 0;
        exp_bad_cnt    = 0;
        exp_strb_total = 0;
        strb_seen      = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        pkt_q  = pkt_q[3:5];
        send_pkt(0);
        wait_drain();
        check_counts("midrst");
        check("midrst_tail_pkt_cnt", DW'(pkt_cnt), DW'(1));
        check("midrst_tail_bad_cnt", DW'(bad_cnt), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
